load_data_extractor: RTL
========================

Name: load_data_extractor

Overview:
Load-side counterpart of the store path. It accepts one load request at a time from the memory stage and drives a read strobe to data memory. It waits, with a timeout, for the memory ready. It then selects the addressed byte or halfword lane from the returned 32-bit word, zero- or sign-extends it to 32 bits, and returns it to writeback with a single-cycle valid pulse.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before a bus fault is raised (must be >= 1)
CNT_W, 5, width of the wait counter (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_req  input  1  load request; sampled only in IDLE
size  input  2  access size using the shared `BYTE / `HALF / `WORD codes; any other value is treated as `WORD
signed_load  input  1  1 = sign-extend BYTE/HALF result, 0 = zero-extend
addr_lo  input  2  byte offset within the word (address bits [1:0])
mem_rdata  input  32  read data from data memory, valid when mem_ready=1
mem_ready  input  1  memory has valid mem_rdata this cycle
mem_rd_en  output  1  read strobe to memory, high throughout WAIT
busy  output  1  high in any state other than IDLE
load_valid  output  1  one-cycle pulse: load_data holds a new result
load_data  output  32  extended load result; holds its value until the next load_valid
align_fault  output  1  one-cycle pulse: misaligned request rejected
bus_fault  output  1  one-cycle pulse: memory did not respond within TIMEOUT_CYCLES

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE; mem_rd_en, busy, load_valid, align_fault and bus_fault are 0; load_data=32'h0; wait counter=0; captured request fields=0.
- All outputs are registered or decoded from the state register. No combinational path exists from inputs to outputs.
- FSM states: IDLE, WAIT, RESP, FAULT.
- IDLE:
  - If load_req=1, capture size, signed_load and addr_lo.
  - Misaligned requests go to FAULT. A request is misaligned if it is HALF with addr_lo[0]=1, or WORD with addr_lo!=0.
  - Otherwise go to WAIT and clear the counter.
  - If load_req=0, stay in IDLE.
- WAIT:
  - mem_rd_en=1.
  - If mem_ready=1: latch the extracted result into load_data and go to RESP. This takes priority over timeout in the same cycle.
  - Else if counter == TIMEOUT_CYCLES-1: go to FAULT with the bus-fault cause.
  - Else: increment the counter.
- RESP: load_valid=1 for exactly one cycle, then go to IDLE. load_req is ignored in RESP.
- FAULT: pulse align_fault or bus_fault according to the latched cause, for one cycle, then go to IDLE. load_data is not updated.
- load_req arriving while busy=1 is ignored. The requester must hold it until it sees busy=0.
- Latency: request accepted at edge 0 puts the block in WAIT during cycle 1. If mem_ready=1 in cycle 1, load_valid is high in cycle 2. Minimum latency is 2 cycles; throughput is at most one load per 3 cycles.
- Extraction, using lane = captured addr_lo:
  - BYTE: mem_rdata[8*lane+7 : 8*lane].
  - HALF: lane 0 gives [15:0]; lane 2 gives [31:16].
  - WORD: mem_rdata unchanged; signed_load has no effect.
  - Extension: bits above the selected field are filled with the field MSB if signed_load=1, otherwise with 0.
- mem_ready outside WAIT is ignored.
- Reset asserted in any state forces IDLE on the next edge. Any in-flight load is dropped with no valid or fault pulse.

Decomposition:
- Size codes (`BYTE/`HALF/`WORD) and the FSM state enum live in the shared codes definitions. Do not redefine them locally.
- One combinational sub-module, load_lane_extract, takes (rdata, size, addr_lo, signed_load) and produces a 32-bit result. It is instantiated in WAIT's capture path and is unit-testable standalone.

Test Plan:
- BYTE, signed, addr_lo=3, mem_rdata=32'h80FF_1234, mem_ready in the first WAIT cycle -> load_valid in cycle 2, load_data=32'hFFFF_FF80.
- HALF, unsigned, addr_lo=2, mem_rdata=32'h9ABC_5678, 3 wait cycles -> mem_rd_en high for 3 cycles, then load_data=32'h0000_9ABC with a single load_valid pulse.
- HALF, addr_lo=1 -> align_fault one cycle, mem_rd_en never asserted, load_data unchanged. Repeat for WORD with addr_lo=2.
- WORD with mem_ready never asserted, TIMEOUT_CYCLES=16 -> mem_rd_en high for exactly 16 cycles, then one bus_fault pulse, then busy=0.
- load_req held high through RESP plus a second request -> exactly one accepted per IDLE visit. The second result is correct: BYTE unsigned, addr_lo=1, rdata 32'h0000_AB00 gives 32'h0000_00AB.
- Reset asserted mid-WAIT, with mem_ready=1 on the same edge -> IDLE next cycle, no load_valid, all outputs at reset values.

Source files
------------

// File: rtl/load_data_extractor_pkg.sv
// Shared codes for the load path: access-size encodings, FSM states and the
// captured request payload.
package load_data_extractor_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    RESP  = 2'b10,
    FAULT = 2'b11
  } state_e;

  typedef enum logic {
    CAUSE_ALIGN = 1'b0,
    CAUSE_BUS   = 1'b1
  } fault_cause_e;

  typedef struct packed {
    logic [1:0] size;
    logic       signed_load;
    logic [1:0] addr_lo;
  } load_req_t;

  // Unknown size codes behave as WORD, so they need full alignment.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      default:   bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_data_extractor_if.sv
// Request/memory/writeback signal bundle of the load data extractor.
interface load_data_extractor_if;

  logic        load_req;
  logic [1:0]  size;
  logic        signed_load;
  logic [1:0]  addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_rd_en;
  logic        busy;
  logic        load_valid;
  logic [31:0] load_data;
  logic        align_fault;
  logic        bus_fault;

  // Requester / memory model side.
  modport master (
    output load_req, size, signed_load, addr_lo, mem_rdata, mem_ready,
    input  mem_rd_en, busy, load_valid, load_data, align_fault, bus_fault
  );

  // Load extractor side.
  modport slave (
    input  load_req, size, signed_load, addr_lo, mem_rdata, mem_ready,
    output mem_rd_en, busy, load_valid, load_data, align_fault, bus_fault
  );

endinterface

// File: rtl/load_lane_extract.sv
// Selects the addressed byte/halfword lane of a 32-bit read word and
// zero- or sign-extends it to 32 bits.
module load_lane_extract
  import load_data_extractor_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        signed_load,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    result   = rdata;

    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SIZE_BYTE: result = {{24{signed_load & byte_sel[7]}}, byte_sel};
      SIZE_HALF: result = {{16{signed_load & half_sel[15]}}, half_sel};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/load_data_extractor.sv
// Load-side memory sequencer: accepts one load at a time, strobes data memory
// with a timeout, and returns the extended lane with a one-cycle valid pulse.
module load_data_extractor
  import load_data_extractor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  load_data_extractor_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  load_req_t        req_q, req_d;
  fault_cause_e     cause_q, cause_d;
  logic [31:0]      data_q, data_d;

  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             align_q, align_d;
  logic             bfault_q, bfault_d;

  logic [31:0]      extract_result;

  load_lane_extract u_extract (
    .rdata       (bus.mem_rdata),
    .size        (req_q.size),
    .addr_lo     (req_q.addr_lo),
    .signed_load (req_q.signed_load),
    .result      (extract_result)
  );

  // State and registered outputs; reset drops any in-flight load silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      cause_q  <= CAUSE_ALIGN;
      data_q   <= 32'h0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      align_q  <= 1'b0;
      bfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      cause_q  <= cause_d;
      data_q   <= data_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      align_q  <= align_d;
      bfault_q <= bfault_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register
  // in step with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cause_d = cause_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (bus.load_req) begin
          req_d.size        = bus.size;
          req_d.signed_load = bus.signed_load;
          req_d.addr_lo     = bus.addr_lo;
          if (is_misaligned(bus.size, bus.addr_lo)) begin
            cause_d = CAUSE_ALIGN;
            state_d = FAULT;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A ready response wins over a timeout in the same cycle.
        if (bus.mem_ready) begin
          data_d  = extract_result;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cause_d = CAUSE_BUS;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_en_d  = (state_d == WAIT);
    busy_d   = (state_d != IDLE);
    valid_d  = (state_d == RESP);
    align_d  = (state_d == FAULT) && (cause_d == CAUSE_ALIGN);
    bfault_d = (state_d == FAULT) && (cause_d == CAUSE_BUS);
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.busy        = busy_q;
  assign bus.load_valid  = valid_q;
  assign bus.load_data   = data_q;
  assign bus.align_fault = align_q;
  assign bus.bus_fault   = bfault_q;

endmodule
